// File: rtl/usb_gpx_conditioner_if.sv
// Avalon-MM slave bus plus interrupt line for the GPX conditioner.
interface usb_gpx_conditioner_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport slave  (input address, chipselect, write, writedata, output readdata, irq);
  modport master (output address, chipselect, write, writedata, input readdata, irq);
endinterface

// File: rtl/usb_gpx_conditioner.sv
// Synchronizes and glitch-filters the USB controller GPX pin, reports edges
// through sticky flags, a saturating rise counter and a level interrupt.
module usb_gpx_conditioner #(
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 gpx_pin,
  output logic                 gpx_clean,
  usb_gpx_conditioner_if.slave bus
);

  localparam logic [7:0]       LP_FC_M1 = 8'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_CMAX  = '1;
  localparam logic [31:0]      LP_INFO  = {18'd0, 6'(CNT_W), 8'(FILTER_CYCLES)};

  logic             r_s1, r_s2, r_clean;
  logic [7:0]       r_fcnt;
  logic             r_rise, r_fall;
  logic [1:0]       r_ctrl;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_readdata;

  logic        w_diff, w_toggle, w_rise, w_fall;
  logic        w_wr, w_wr_stat, w_wr_ctrl, w_wr_cnt;
  logic [31:0] w_rdmux;
  logic        w_unused;

  // Toggle fires on the FILTER_CYCLES-th consecutive disagreeing sample.
  assign w_diff   = r_s2 ^ r_clean;
  assign w_toggle = w_diff && (r_fcnt == LP_FC_M1);
  assign w_rise   = w_toggle & ~r_clean;
  assign w_fall   = w_toggle &  r_clean;

  assign w_wr      = bus.chipselect & bus.write;
  assign w_wr_stat = w_wr && (bus.address == 2'd0);
  assign w_wr_ctrl = w_wr && (bus.address == 2'd1);
  assign w_wr_cnt  = w_wr && (bus.address == 2'd2);
  assign w_unused  = ^bus.writedata[31:2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_clean <= 1'b0;
      r_fcnt  <= '0;
    end else begin
      r_s1 <= gpx_pin;
      r_s2 <= r_s1;
      if (!w_diff || w_toggle) r_fcnt <= '0;
      else                     r_fcnt <= r_fcnt + 8'd1;
      if (w_toggle) r_clean <= ~r_clean;
    end
  end

  // A new event beats a simultaneous W1C; a rise beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_ctrl  <= '0;
      r_count <= '0;
    end else begin
      if (w_rise)                            r_rise <= 1'b1;
      else if (w_wr_stat && bus.writedata[1]) r_rise <= 1'b0;
      if (w_fall)                            r_fall <= 1'b1;
      else if (w_wr_stat && bus.writedata[2]) r_fall <= 1'b0;
      if (w_wr_ctrl) r_ctrl <= bus.writedata[1:0];
      if (w_wr_cnt)                    r_count <= w_rise ? CNT_W'(1) : '0;
      else if (w_rise && r_count != LP_CMAX) r_count <= r_count + CNT_W'(1);
    end
  end

  always_comb begin
    w_rdmux = '0;
    case (bus.address)
      2'd0:    w_rdmux = {29'd0, r_fall, r_rise, r_clean};
      2'd1:    w_rdmux = {30'd0, r_ctrl};
      2'd2:    w_rdmux = 32'(r_count);
      default: w_rdmux = LP_INFO;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               r_readdata <= '0;
    else if (bus.chipselect) r_readdata <= w_rdmux;
  end

  assign gpx_clean    = r_clean;
  assign bus.readdata = r_readdata;
  assign bus.irq      = (r_rise & r_ctrl[0]) | (r_fall & r_ctrl[1]);

endmodule
